// File: rtl/mdu_unit.sv
// Iterative 8-bit multiply/divide unit: shift-add multiply, restoring divide, 8 iterations.
// Define MDU_SIGNED_EN to enable two's-complement operation selected by op[1].
module mdu_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] input1,
  input  logic [7:0] input2,
  output logic       busy,
  output logic       done,
  output logic [7:0] hi,
  output logic [7:0] lo,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic [7:0]  opnd_q, opnd_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic        dbz_q, dbz_d;

  logic        accept;
  logic [7:0]  mag_a, mag_b;
  logic [8:0]  mul_sum, div_shift, div_trial;
  logic [15:0] acc_step, res_fix;

  assign accept = start && (state_q == IDLE || state_q == DONE);

`ifdef MDU_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_lo_q, neg_hi_q;

  assign a_neg = op[1] & input1[7];
  assign b_neg = op[1] & input2[7];
  assign mag_a = a_neg ? (~input1 + 8'd1) : input1;
  assign mag_b = b_neg ? (~input2 + 8'd1) : input2;

  // Product and quotient take the XOR of operand signs; the remainder follows the dividend.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (accept) begin
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg;
    end
  end

  always_comb begin
    if (!is_div_q) begin
      res_fix = neg_lo_q ? (~acc_step + 16'd1) : acc_step;
    end else begin
      res_fix[15:8] = neg_hi_q ? (~acc_step[15:8] + 8'd1) : acc_step[15:8];
      res_fix[7:0]  = neg_lo_q ? (~acc_step[7:0] + 8'd1)  : acc_step[7:0];
    end
  end
`else
  logic unused_op1;
  assign unused_op1 = op[1];
  assign mag_a      = input1;
  assign mag_b      = input2;
  assign res_fix    = acc_step;
`endif

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  assign mul_sum   = {1'b0, acc_q[15:8]} + {1'b0, (acc_q[0] ? opnd_q : 8'h00)};
  assign div_shift = {acc_q[15:8], acc_q[7]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  always_comb begin
    if (!is_div_q) begin
      acc_step = {mul_sum, acc_q[7:1]};
    end else if (div_trial[8]) begin
      acc_step = {div_shift[7:0], acc_q[6:0], 1'b0};
    end else begin
      acc_step = {div_trial[7:0], acc_q[6:0], 1'b1};
    end
  end

  // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          is_div_d = op[0];
          cnt_d    = 3'd0;
          dbz_d    = 1'b0;
          if (op[0] && input2 == 8'h00) begin
            state_d = DONE;
            hi_d    = input1;
            lo_d    = 8'hFF;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            opnd_d  = op[0] ? mag_b : mag_a;
            acc_d   = {8'h00, (op[0] ? mag_a : mag_b)};
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          hi_d    = res_fix[15:8];
          lo_d    = res_fix[7:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      is_div_q <= 1'b0;
      opnd_q   <= 8'h00;
      acc_q    <= 16'h0000;
      hi_q     <= 8'h00;
      lo_q     <= 8'h00;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed scoreboard bench for mdu_unit; expectations come from an integer reference model.
// Latency is counted in clock edges from the accepting edge through the edge that raises done.
module tb_mdu_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] input1, input2;
  logic       busy, done, div_by_zero;
  logic [7:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_hi, last_lo;

  typedef struct {
    string      tag;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       dbz;
    int         lat;
    int         busy_cycles;
  } exp_t;

  exp_t sb[$];

  mdu_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .input1(input1), .input2(input2),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [1:0] o,
                                 input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    bit sgn;
    int ia, ib, q, r;
    logic [15:0] p;
    sgn = 1'b0;
`ifdef MDU_SIGNED_EN
    sgn = o[1];
`endif
    e.tag = tag; e.dbz = 1'b0; e.lat = 9; e.busy_cycles = 8;
    ia = sgn ? int'($signed(a)) : int'(a);
    ib = sgn ? int'($signed(b)) : int'(b);
    if (!o[0]) begin
      p = 16'(ia * ib);
      e.hi = p[15:8]; e.lo = p[7:0];
    end else if (b == 8'h00) begin
      e.hi = a; e.lo = 8'hFF; e.dbz = 1'b1; e.lat = 1; e.busy_cycles = 0;
    end else begin
      q = ia / ib;
      r = ia % ib;
      e.lo = 8'(q); e.hi = 8'(r);
    end
    return e;
  endfunction

  // Drives one request, optionally pulsing a stray start at a given cycle, then scores the result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] a,
                        input logic [7:0] b, input int pulse_at);
    exp_t e;
    int   cyc, bcnt;
    bit   partial;
    @(negedge clk);
    op = o; input1 = a; input2 = b; start = 1'b1;
    sb.push_back(model(tag, o, a, b));
    @(posedge clk); #1;
    start = 1'b0; cyc = 1; bcnt = 0; partial = 1'b0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      if (hi !== last_hi || lo !== last_lo) partial = 1'b1;
      if (cyc == pulse_at) begin
        start = 1'b1; op = 2'b00; input1 = 8'd5; input2 = 8'd5;
      end else begin
        start = 1'b0; input1 = 8'($urandom); input2 = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({e.tag, " done"}, 16'(done), 16'd1);
    check({e.tag, " latency"}, 16'(cyc), 16'(e.lat));
    check({e.tag, " busy_cycles"}, 16'(bcnt), 16'(e.busy_cycles));
    check({e.tag, " hi"}, 16'(hi), 16'(e.hi));
    check({e.tag, " lo"}, 16'(lo), 16'(e.lo));
    check({e.tag, " dbz"}, 16'(div_by_zero), 16'(e.dbz));
    check({e.tag, " no_partial"}, 16'(partial), 16'd0);
    last_hi = hi; last_lo = lo;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"}, 16'(busy), 16'd0);
    check({tag, " done"}, 16'(done), 16'd0);
    check({tag, " hi"}, 16'(hi), 16'd0);
    check({tag, " lo"}, 16'(lo), 16'd0);
    check({tag, " dbz"}, 16'(div_by_zero), 16'd0);
  endtask

  initial begin
    bit saw;
    rst = 1'b1; start = 1'b0; op = 2'b00; input1 = 8'h00; input2 = 8'h00;
    last_hi = 8'h00; last_lo = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk) rst = 1'b0;

    run_op("mul_200x3", 2'b00, 8'd200, 8'd3, 0);
    @(posedge clk); #1;
    check("done_one_cycle", 16'(done), 16'd0);

    run_op("div_200/7", 2'b01, 8'd200, 8'd7, 0);
    run_op("div_255/16_b2b", 2'b01, 8'd255, 8'd16, 0);

    run_op("div_37/0", 2'b01, 8'h37, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    check("dbz_held", 16'(div_by_zero), 16'd1);
    run_op("mul_after_dbz", 2'b00, 8'd13, 8'd11, 0);

    run_op("mul_10x10_stray", 2'b00, 8'd10, 8'd10, 3);
    run_op("mul_255x255", 2'b00, 8'd255, 8'd255, 0);
    run_op("div_1/255", 2'b01, 8'd1, 8'd255, 0);
    run_op("mul_x0", 2'b00, 8'd77, 8'd0, 0);

    run_op("op10_FAx7", 2'b10, 8'hFA, 8'd7, 0);
    run_op("op11_80/FF", 2'b11, 8'h80, 8'hFF, 0);
    run_op("op11_F9/2", 2'b11, 8'hF9, 8'd2, 0);
    run_op("op11_dbz", 2'b11, 8'h9C, 8'h00, 0);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    op = 2'b00; input1 = 8'd255; input2 = 8'd255; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("rst_mid_calc");
    rst = 1'b0;
    last_hi = 8'h00; last_lo = 8'h00;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1'b1;
    end
    check("no_done_after_rst", 16'(saw), 16'd0);
    run_op("mul_2x2", 2'b00, 8'd2, 8'd2, 0);

    // Reset and start together: the request is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 2'b00; input1 = 8'd3; input2 = 8'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_idle_zero("rst_with_start");
    @(posedge clk); #1;
    check("rst_start_dropped", 16'(busy), 16'd0);

    check("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
